// File: rtl/contador_param.sv
// rtl/contador_param.sv - parametrised up/down/step/modulo counter with registered rco
// Optional build macro: CONTADOR_SATURATE_EN (step modes clamp at the bounds instead of wrapping).
module contador_param #(
  parameter int WIDTH = 8,
  parameter int STEP  = 3,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco
);

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_UP1   = 3'b001,
    M_DN1   = 3'b010,
    M_UPS   = 3'b011,
    M_DNS   = 3'b100,
    M_LOAD  = 3'b101,
    M_MODUP = 3'b110,
    M_CLEAR = 3'b111
  } modo_t;

  localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] TOP    = '1;

  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q_next;
  logic             rco_next;
  logic             step_mode;
  logic             up_dir;

  assign q_x = {1'b0, Q};

  // One extra bit: for up modes it is the carry, for down modes the borrow.
  always_comb begin
    sum       = q_x;
    step_mode = 1'b1;
    up_dir    = 1'b0;
    case (modo)
      M_UP1:   begin sum = q_x + ONE_X;  up_dir = 1'b1; end
      M_DN1:   sum = q_x - ONE_X;
      M_UPS:   begin sum = q_x + STEP_X; up_dir = 1'b1; end
      M_DNS:   sum = q_x - STEP_X;
      default: step_mode = 1'b0;
    endcase
  end

  always_comb begin
    q_next   = Q;
    rco_next = 1'b0;
    if (enable) begin
      if (step_mode) begin
`ifdef CONTADOR_SATURATE_EN
        if (up_dir && (sum[WIDTH] || sum[WIDTH-1:0] == TOP)) begin
          q_next   = TOP;
          rco_next = 1'b1;
        end else if (!up_dir && (sum[WIDTH] || sum[WIDTH-1:0] == '0)) begin
          q_next   = '0;
          rco_next = 1'b1;
        end else begin
          q_next = sum[WIDTH-1:0];
        end
`else
        q_next   = sum[WIDTH-1:0];
        rco_next = sum[WIDTH];
`endif
      end else begin
        case (modo)
          M_LOAD:  q_next = D;
          M_MODUP: begin
            if (Q >= MAX_V) begin
              q_next   = '0;
              rco_next = 1'b1;
            end else begin
              q_next = Q + WIDTH'(1);
            end
          end
          M_CLEAR: q_next = '0;
          default: q_next = Q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Q   <= '0;
      rco <= 1'b0;
    end else begin
      Q   <= q_next;
      rco <= rco_next;
    end
  end

endmodule
